// File: rtl/snn_inference_sequencer.sv
// Frame-level sequencer for a spiking neural network: presents one input frame for num_steps
// timesteps, accumulates output spikes and reports the winning class. Optional SNN_SEQ_TIMEOUT_EN.
module snn_inference_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             system_clock,
  input  logic             rst_n,
  input  logic [7:0]       frame_in,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic [7:0]       num_steps,
  input  logic             abort,
  output logic [7:0]       snn_spikes,
  output logic             snn_start,
  input  logic             snn_done,
  input  logic [1:0]       snn_out,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic             winner,
  output logic             tie,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  if (CNT_W < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("snn_inference_sequencer: CNT_W and TIMEOUT must be >= 1");
  end

  state_t     state, state_nxt;
  logic [7:0] steps_q;
  logic [7:0] step_cnt;
  logic       accept;
  logic       step_last;
  logic       abort_act;
  logic       timeout_hit;

  assign accept    = frame_valid && frame_ready;
  assign step_last = (step_cnt + 8'd1) == steps_q;
  assign abort_act = abort && (state != IDLE);

`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  // The last permitted WAIT cycle is the TIMEOUT-th one; a snn_done arriving in it still wins.
  assign timeout_hit = (state == WAIT) && !snn_done && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == STEP) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (accept) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit && !abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    frame_ready  = 1'b0;
    snn_start    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        frame_ready = 1'b1;
        busy        = 1'b0;
        if (accept) begin
          state_nxt = (num_steps == 8'd0) ? DONE : STEP;
        end
      end
      STEP: begin
        snn_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (snn_done) begin
          state_nxt = step_last ? DONE : STEP;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_act) begin
      state_nxt = IDLE;
    end
  end

  // Result flags are qualified by DONE so that idle/reset outputs read all-zero.
  assign winner = result_valid && (count1 > count0);
  assign tie    = result_valid && (count0 == count1);

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      snn_spikes <= 8'h00;
      steps_q    <= 8'h00;
      step_cnt   <= 8'h00;
      count0     <= '0;
      count1     <= '0;
    end else if (accept) begin
      snn_spikes <= frame_in;
      steps_q    <= num_steps;
      step_cnt   <= 8'h00;
      count0     <= '0;
      count1     <= '0;
    end else if (abort_act) begin
      count0 <= '0;
      count1 <= '0;
    end else if (state == WAIT && snn_done) begin
      step_cnt <= step_cnt + 8'd1;
      if (snn_out[0] && count0 != {CNT_W{1'b1}}) begin
        count0 <= count0 + 1'b1;
      end
      if (snn_out[1] && count1 != {CNT_W{1'b1}}) begin
        count1 <= count1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed bench for snn_inference_sequencer: a CNT_W=8 instance plus a CNT_W=2 instance
// sharing stimulus, with the SNN handshake driven by hand from per-scenario tasks.
module tb_snn_inference_sequencer;

  logic       system_clock = 1'b0;
  logic       rst_n        = 1'b0;
  logic [7:0] frame_in     = 8'h00;
  logic       frame_valid  = 1'b0;
  logic [7:0] num_steps    = 8'h00;
  logic       abort        = 1'b0;
  logic       snn_done     = 1'b0;
  logic [1:0] snn_out      = 2'b00;
  logic       result_ready = 1'b0;

  logic       frame_ready, snn_start, winner, tie, result_valid, busy, timeout_err;
  logic [7:0] snn_spikes, count0, count1;

  logic       s_frame_ready, s_snn_start, s_winner, s_tie, s_result_valid, s_busy, s_timeout_err;
  logic [7:0] s_snn_spikes;
  logic [1:0] s_count0, s_count1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  snn_inference_sequencer #(.CNT_W(8), .TIMEOUT(16)) dut (
    .system_clock(system_clock), .rst_n(rst_n),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .num_steps(num_steps), .abort(abort), .snn_spikes(snn_spikes), .snn_start(snn_start),
    .snn_done(snn_done), .snn_out(snn_out), .count0(count0), .count1(count1),
    .winner(winner), .tie(tie), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  snn_inference_sequencer #(.CNT_W(2), .TIMEOUT(16)) dut_sat (
    .system_clock(system_clock), .rst_n(rst_n),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(s_frame_ready),
    .num_steps(num_steps), .abort(abort), .snn_spikes(s_snn_spikes), .snn_start(s_snn_start),
    .snn_done(snn_done), .snn_out(snn_out), .count0(s_count0), .count1(s_count1),
    .winner(s_winner), .tie(s_tie), .result_valid(s_result_valid), .result_ready(result_ready),
    .busy(s_busy), .timeout_err(s_timeout_err)
  );

  always #5 system_clock = ~system_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge system_clock);
    #1;
    cyc++;
  endtask

  task automatic accept_frame(input logic [7:0] f, input logic [7:0] n);
    frame_in    = f;
    num_steps   = n;
    frame_valid = 1'b1;
    cyc         = 0;
    tick();
    frame_valid = 1'b0;
    frame_in    = ~f;
    num_steps   = 8'h00;
  endtask

  task automatic do_step(input logic [1:0] o);
    int w = 0;
    while (snn_start !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_start_wait: snn_start not seen within 20 cycles, required 1");
    end else begin
      tick();
      snn_done = 1'b1;
      snn_out  = o;
      tick();
      snn_done = 1'b0;
      snn_out  = 2'b00;
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  function automatic logic [30:0] out_vec();
    return {frame_ready, snn_spikes, snn_start, count0, count1, winner, tie, result_valid,
            busy, timeout_err};
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_vec() !== 31'h4000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required %h", out_vec(), 31'h4000_0000);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (frame_ready !== 1'b1 || snn_spikes !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b spikes=%h busy=%b required 1 00 0",
               frame_ready, snn_spikes, busy);
    end
  endtask

  task automatic test_basic();
    accept_frame(8'hA5, 8'd4);
    n_checks++;
    if (snn_start !== 1'b1 || snn_spikes !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_start: start=%b spikes=%h required 1 a5", snn_start, snn_spikes);
    end
    do_step(2'b01);
    do_step(2'b11);
    do_step(2'b00);
    do_step(2'b10);
    n_checks++;
    if (result_valid !== 1'b1 || cyc !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: result_valid=%b at cycle %0d required 1 at 9", result_valid, cyc);
    end
    n_checks++;
    if ({count0, count1, tie, winner, frame_ready} !== {8'd2, 8'd2, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: c0=%0d c1=%0d tie=%b win=%b ready=%b required 2 2 1 0 0",
               count0, count1, tie, winner, frame_ready);
    end
    snn_done = 1'b1;
    snn_out  = 2'b11;
    tick();
    snn_done = 1'b0;
    snn_out  = 2'b00;
    n_checks++;
    if (count0 !== 8'd2 || count1 !== 8'd2 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignored: c0=%0d c1=%0d valid=%b required 2 2 1", count0, count1, result_valid);
    end
    release_result();
    n_checks++;
    if (frame_ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0 || snn_spikes !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_release: ready=%b valid=%b busy=%b spikes=%h required 1 0 0 a5",
               frame_ready, result_valid, busy, snn_spikes);
    end
  endtask

  task automatic test_zero_steps();
    accept_frame(8'h3C, 8'd0);
    n_checks++;
    if ({result_valid, snn_start, count0, count1, tie} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_steps: valid=%b start=%b c0=%0d c1=%0d tie=%b required 1 0 0 0 1",
               result_valid, snn_start, count0, count1, tie);
    end
    release_result();
  endtask

  task automatic test_winner();
    accept_frame(8'h0F, 8'd3);
    do_step(2'b10);
    do_step(2'b10);
    do_step(2'b01);
    n_checks++;
    if ({count0, count1, winner, tie, result_valid} !== {8'd1, 8'd2, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL winner: c0=%0d c1=%0d win=%b tie=%b valid=%b required 1 2 1 0 1",
               count0, count1, winner, tie, result_valid);
    end
    release_result();
  endtask

  task automatic test_saturation();
    accept_frame(8'hFF, 8'd6);
    for (int i = 0; i < 6; i++) do_step(2'b11);
    n_checks++;
    if ({s_count0, s_count1, s_tie, s_result_valid} !== {2'd3, 2'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate_narrow: c0=%0d c1=%0d tie=%b valid=%b required 3 3 1 1",
               s_count0, s_count1, s_tie, s_result_valid);
    end
    n_checks++;
    if (count0 !== 8'd6 || count1 !== 8'd6) begin
      n_fail++;
      $display("FAIL saturate_wide: c0=%0d c1=%0d required 6 6", count0, count1);
    end
    release_result();
  endtask

  task automatic test_abort();
    bit saw_valid = 1'b0;
    accept_frame(8'h5A, 8'd4);
    do_step(2'b11);
    tick();
    snn_done = 1'b1;
    snn_out  = 2'b11;
    abort    = 1'b1;
    tick();
    snn_done = 1'b0;
    snn_out  = 2'b00;
    abort    = 1'b0;
    n_checks++;
    if ({busy, frame_ready, count0, count1, result_valid} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b ready=%b c0=%0d c1=%0d valid=%b required 0 1 0 0 0",
               busy, frame_ready, count0, count1, result_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (result_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result: result_valid seen=%b required 0", saw_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (frame_ready !== 1'b1 || busy !== 1'b0 || snn_spikes !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_idle: ready=%b busy=%b spikes=%h required 1 0 5a",
               frame_ready, busy, snn_spikes);
    end
  endtask

  task automatic test_max_steps();
    accept_frame(8'h81, 8'd255);
    for (int i = 0; i < 255; i++) do_step(2'b01);
    n_checks++;
    if (result_valid !== 1'b1 || cyc !== 511) begin
      n_fail++;
      $display("FAIL max_steps_latency: valid=%b at cycle %0d required 1 at 511", result_valid, cyc);
    end
    n_checks++;
    if ({count0, count1, winner, tie} !== {8'd255, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL max_steps_counts: c0=%0d c1=%0d win=%b tie=%b required 255 0 0 0",
               count0, count1, winner, tie);
    end
    release_result();
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    accept_frame(8'h11, 8'd1);
    tick();
`ifdef SNN_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (result_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: left WAIT before 16 cycles=%b required 0", early);
    end
    tick();
    n_checks++;
    if ({result_valid, timeout_err, count0, count1} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL timeout_done: valid=%b terr=%b c0=%0d c1=%0d required 1 1 0 0",
               result_valid, timeout_err, count0, count1);
    end
    release_result();
    n_checks++;
    if (timeout_err !== 1'b1 || frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: terr=%b ready=%b required 1 1", timeout_err, frame_ready);
    end
    accept_frame(8'h22, 8'd1);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: terr=%b required 0", timeout_err);
    end
    do_step(2'b10);
    release_result();
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy !== 1'b1 || result_valid !== 1'b0 || snn_start !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever: left WAIT=%b terr=%b required 0 0", early, timeout_err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_abort: busy=%b ready=%b required 0 1", busy, frame_ready);
    end
`endif
  endtask

  task automatic test_reset_mid();
    accept_frame(8'hC3, 8'd3);
    do_step(2'b11);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 31'h4000_0000) begin
      n_fail++;
      $display("FAIL reset_async: got %h required %h", out_vec(), 31'h4000_0000);
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_vec() !== 31'h4000_0000) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %h required %h", out_vec(), 31'h4000_0000);
    end
    accept_frame(8'hE7, 8'd2);
    do_step(2'b01);
    do_step(2'b01);
    n_checks++;
    if ({result_valid, count0, count1, winner, tie, snn_spikes} !==
        {1'b1, 8'd2, 8'd0, 1'b0, 1'b0, 8'hE7} || cyc !== 5) begin
      n_fail++;
      $display("FAIL reset_next_frame: valid=%b c0=%0d c1=%0d win=%b tie=%b spikes=%h cyc=%0d required 1 2 0 0 0 e7 5",
               result_valid, count0, count1, winner, tie, snn_spikes, cyc);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_winner();
    test_saturation();
    test_abort();
    test_max_steps();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
